serial_adder_acc: RTL and testbench
===================================

SERIAL_ADDER_ACC -- requirements
Module: serial_adder_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits.
REQ-002 SHALL have parameter SLICE, default 4, bits added per cycle; WIDTH % SLICE == 0 and SLICE >= 1; NSL = WIDTH/SLICE.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  operand set present.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port a  input  WIDTH  operand A; ignored when acc_en=1.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port cin  input  1  carry in for add, borrow in for subtract.
REQ-010 SHALL have port sub  input  1  0 = add, 1 = subtract.
REQ-011 SHALL have port acc_en  input  1  use internal accumulator in place of a.
REQ-012 SHALL have port out_valid  output  1  result available.
REQ-013 SHALL have port out_ready  input  1  consumer takes result.
REQ-014 SHALL have port s  output  WIDTH  sum/difference.
REQ-015 SHALL have port cout  output  1  raw carry out of MSB; in subtract mode, borrow = ~cout.
REQ-016 SHALL have port ovf  output  1  two's-complement overflow.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-018 On in_valid&&in_ready in IDLE, SHALL latch opA = acc_en ? acc : a, opB = sub ? ~b : b, carry = cin ^ sub, slice counter = 0, and go to RUN.
REQ-019 Add result SHALL be a + b + cin; subtract result SHALL be a - b - cin (mod 2^WIDTH).
REQ-020 In RUN, each cycle SHALL add slice k (bits k*SLICE .. k*SLICE+SLICE-1), LSB slice first, using the registered carry, store the slice sum, register the slice carry-out, and increment k.
REQ-021 After slice NSL-1, SHALL go to DONE; out_valid SHALL rise exactly NSL cycles after the accept edge (NSL=1 gives 1 cycle).
REQ-022 ovf SHALL equal the carry into bit WIDTH-1 XOR the carry out of bit WIDTH-1.
REQ-023 In DONE, s/cout/ovf SHALL hold stable until out_valid&&out_ready, then the FSM SHALL return to IDLE in the same edge.
REQ-024 acc SHALL be loaded with s on the out_valid&&out_ready edge only; acc is unchanged otherwise.
REQ-025 in_valid, a, b, cin, sub and acc_en SHALL be ignored outside IDLE; no operand overlap or queuing.
REQ-026 s, cout and ovf SHALL keep the last result after returning to IDLE until the next RUN writes them.
REQ-027 Operand inputs SHALL NOT be required stable after the accept edge.

Reset
REQ-028 rst_n=0 at a clk edge SHALL force state IDLE, slice counter 0, acc=0, s=0, cout=0, ovf=0, out_valid=0, in_ready=1 after that edge.
REQ-029 Reset during RUN or DONE SHALL abort the operation with no acc update; the first operation after reset SHALL be correct.
REQ-030 With rst_n=0, in_valid SHALL NOT be accepted.

Verification (WIDTH=16, SLICE=4 unless noted)
REQ-031 a=0xFFFF, b=0x0001, cin=0, sub=0 -> s=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
REQ-032 a=0x7FFF, b=0x0001, cin=0, sub=0 -> s=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, cin=0, sub=1 -> s=0xFFFE, cout=0 (borrow), ovf=0.
REQ-033 After reset, three ops acc_en=1, b=0x0003, cin=0, sub=0, out_ready=1 -> s=0x0003, 0x0006, 0x0009; a toggled randomly with no effect.
REQ-034 out_ready=0 for 5 cycles in DONE with in_valid=1 -> s/cout/ovf stable, in_ready=0, nothing accepted; out_ready=1 -> IDLE next edge, acc updated once.
REQ-035 rst_n=0 for one edge at slice 2 of a RUN -> all outputs 0, in_ready=1, acc=0; next op a=0x1234, b=0x1111 -> s=0x2345.
REQ-036 Random sweep for SLICE in {1,4,16} against a + b + cin / a - b - cin reference -> s, cout, ovf match; latency = NSL cycles.

Source files
------------

// File: rtl/serial_adder_acc.sv
// serial_adder_acc
//   Digit-serial adder/subtractor with a result accumulator. One operand set
//   is accepted in IDLE. The sum is then built SLICE bits per cycle, least
//   significant slice first, over NSL = WIDTH/SLICE cycles. The result is
//   held in DONE until the consumer takes it. Taking the result also loads
//   it into the accumulator, which can replace operand A on a later op.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operand set present          in_ready   idle, can accept
//   a, b       operands (a ignored when acc_en=1)
//   cin        carry in (add) / borrow in (subtract)
//   sub        0 = a+b+cin, 1 = a-b-cin
//   acc_en     use accumulator in place of a
//   out_valid  result available             out_ready  consumer takes result
//   s          sum/difference
//   cout       raw carry out of the MSB (borrow = ~cout when subtracting)
//   ovf        two's-complement overflow
//
// State table
//   state | meaning
//   IDLE  | waiting for an operand set, in_ready=1
//   RUN   | adding slice k each cycle
//   DONE  | result valid, held until out_ready
module serial_adder_acc #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             acc_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int NSL = WIDTH / SLICE;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam int IW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] opa, opb, acc;
  logic             carry;
  logic [KW-1:0]    k;
  logic [IW-1:0]    base;
  logic [SLICE-1:0] sl_a, sl_b, sl_s;
  logic [SLICE:0]   sl_sum;
  logic             msb_cin;
  logic             last, accept, pop;

  assign base   = IW'(32'(k) * 32'(SLICE));
  assign sl_a   = opa[base +: SLICE];
  assign sl_b   = opb[base +: SLICE];
  assign sl_sum = {1'b0, sl_a} + {1'b0, sl_b} + {{SLICE{1'b0}}, carry};
  assign sl_s   = sl_sum[SLICE-1:0];
  // Carry into the slice MSB recovered from its sum bit: s = a ^ b ^ c.
  // Works for SLICE=1, where no lower bits exist to add separately.
  assign msb_cin = sl_s[SLICE-1] ^ sl_a[SLICE-1] ^ sl_b[SLICE-1];
  assign last    = (k == K_LAST);
  assign accept  = in_valid && in_ready;
  assign pop     = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      k     <= '0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      acc   <= '0;
    end else begin
      if (accept) begin
        opa   <= acc_en ? acc : a;
        // Subtract as a + ~b + 1 - cin, so the initial carry is ~cin.
        opb   <= sub ? ~b : b;
        carry <= cin ^ sub;
        k     <= '0;
      end
      if (state == RUN) begin
        s[base +: SLICE] <= sl_s;
        carry            <= sl_sum[SLICE];
        k                <= last ? '0 : k + KW'(1);
        if (last) begin
          cout <= sl_sum[SLICE];
          ovf  <= msb_cin ^ sl_sum[SLICE];
        end
      end
      if (pop) acc <= s;
    end
  end

endmodule

// File: tb/tb_serial_adder_acc.sv
// tb_serial_adder_acc
//   Directed and random checks of serial_adder_acc. The main instance uses
//   WIDTH=16, SLICE=4. Two more instances (SLICE=1 and SLICE=16) share its
//   inputs and are checked in the random sweep.
module tb_serial_adder_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] a, b;
  logic        cin, sub, acc_en, out_ready;

  logic        ir4, ov4, co4, of4;
  logic [15:0] s4;
  logic        ir1, ov1, co1, of1;
  logic [15:0] s1;
  logic        ir16, ov16, co16, of16;
  logic [15:0] s16;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_acc #(.WIDTH(16), .SLICE(4)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir4),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(acc_en),
    .out_valid(ov4), .out_ready(out_ready), .s(s4), .cout(co4), .ovf(of4));

  serial_adder_acc #(.WIDTH(16), .SLICE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(acc_en),
    .out_valid(ov1), .out_ready(out_ready), .s(s1), .cout(co1), .ovf(of1));

  serial_adder_acc #(.WIDTH(16), .SLICE(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir16),
    .a(a), .b(b), .cin(cin), .sub(sub), .acc_en(acc_en),
    .out_valid(ov16), .out_ready(out_ready), .s(s16), .cout(co16), .ovf(of16));

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        of;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a      = 16'($urandom);
    b      = 16'($urandom);
    cin    = 1'($urandom);
    sub    = 1'($urandom);
    acc_en = 1'($urandom);
  endtask

  task automatic pop();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Issues one operand set and waits for u4 to finish. Operand inputs are
  // scrambled while it runs. lat = cycles from the accept edge to out_valid.
  task automatic run_op(input logic [15:0] ai, input logic [15:0] bi,
                        input logic ci, input logic si, input logic ae,
                        output int lat);
    a = ai; b = bi; cin = ci; sub = si; acc_en = ae;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!ov4 && lat < 40) begin
      scramble();
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; a = 16'h1111; b = 16'h2222;
    cin = 1'b0; sub = 1'b0; acc_en = 1'b0; out_ready = 1'b0;
    tick();
    tick();
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset in_ready: got %b want 1", ir4); end
    n_checks++; if (ov4 !== 1'b0) begin n_fail++; $display("FAIL reset out_valid: got %b want 0", ov4); end
    n_checks++; if (s4 !== 16'h0000) begin n_fail++; $display("FAIL reset s: got %h want 0000", s4); end
    n_checks++; if ({co4, of4} !== 2'b00) begin n_fail++; $display("FAIL reset cout/ovf: got %b%b want 00", co4, of4); end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    tick();
    n_checks++; if (ir4 !== 1'b1) begin n_fail++; $display("FAIL reset no-accept in_ready: got %b want 1", ir4); end
  endtask

  task automatic test_vectors();
    vec_t vecs [8];
    int lat;
    vecs[0] = {16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[1] = {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[2] = {16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[3] = {16'h1234, 16'h1111, 1'b1, 1'b0, 16'h2346, 1'b0, 1'b0};
    vecs[4] = {16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};
    vecs[5] = {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, 1'b0, lat);
      n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL vec%0d latency: got %0d want 4", i, lat); end
      n_checks++; if (s4 !== vecs[i].s) begin n_fail++; $display("FAIL vec%0d s: got %h want %h", i, s4, vecs[i].s); end
      n_checks++; if (co4 !== vecs[i].co) begin n_fail++; $display("FAIL vec%0d cout: got %b want %b", i, co4, vecs[i].co); end
      n_checks++; if (of4 !== vecs[i].of) begin n_fail++; $display("FAIL vec%0d ovf: got %b want %b", i, of4, vecs[i].of); end
      n_checks++; if (ir4 !== 1'b0) begin n_fail++; $display("FAIL vec%0d in_ready in DONE: got %b want 0", i, ir4); end
      pop();
      n_checks++; if ({ov4, ir4} !== 2'b01) begin n_fail++; $display("FAIL vec%0d after pop out_valid/in_ready: got %b%b want 01", i, ov4, ir4); end
    end
  endtask

  task automatic test_accumulate();
    int lat;
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      run_op(16'($urandom), 16'h0003, 1'b0, 1'b0, 1'b1, lat);
      n_checks++; if (s4 !== 16'(3 * (i + 1))) begin n_fail++; $display("FAIL acc step%0d s: got %h want %h", i, s4, 16'(3 * (i + 1))); end
      pop();
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    run_op(16'h0100, 16'h0023, 1'b0, 1'b0, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      scramble();
      tick();
      n_checks++; if ({ov4, ir4} !== 2'b10) begin n_fail++; $display("FAIL hold%0d out_valid/in_ready: got %b%b want 10", i, ov4, ir4); end
      n_checks++; if ({s4, co4, of4} !== {16'h0123, 2'b00}) begin n_fail++; $display("FAIL hold%0d s/cout/ovf: got %h %b %b want 0123 0 0", i, s4, co4, of4); end
    end
    in_valid = 1'b0;
    pop();
    n_checks++; if ({ov4, ir4} !== 2'b01) begin n_fail++; $display("FAIL hold release out_valid/in_ready: got %b%b want 01", ov4, ir4); end
    tick();
    n_checks++; if (s4 !== 16'h0123) begin n_fail++; $display("FAIL idle keeps s: got %h want 0123", s4); end
    run_op(16'hDEAD, 16'h0000, 1'b0, 1'b0, 1'b1, lat);
    n_checks++; if (s4 !== 16'h0123) begin n_fail++; $display("FAIL acc after hold: got %h want 0123", s4); end
    pop();
  endtask

  task automatic test_reset_midrun();
    int lat;
    a = 16'hAAAA; b = 16'h5555; cin = 1'b1; sub = 1'b0; acc_en = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    pulse_reset();
    n_checks++; if ({ov4, ir4} !== 2'b01) begin n_fail++; $display("FAIL midrun reset out_valid/in_ready: got %b%b want 01", ov4, ir4); end
    n_checks++; if ({s4, co4, of4} !== 18'h0) begin n_fail++; $display("FAIL midrun reset s/cout/ovf: got %h %b %b want 0000 0 0", s4, co4, of4); end
    run_op(16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b1, lat);
    n_checks++; if (s4 !== 16'h0000) begin n_fail++; $display("FAIL midrun reset acc: got %h want 0000", s4); end
    pop();
    run_op(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b0, lat);
    n_checks++; if ({s4, co4, of4} !== {16'h2345, 2'b00}) begin n_fail++; $display("FAIL first op after reset: got %h %b %b want 2345 0 0", s4, co4, of4); end
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL first op after reset latency: got %0d want 4", lat); end
    pop();
  endtask

  task automatic test_sweep();
    logic [15:0] ra, rb, es;
    logic        rc, rs, eco, eof;
    logic [16:0] w;
    int          t, lat1, lat4, lat16;
    pulse_reset();
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      if (i == 0) begin ra = 16'h7FFF; rb = 16'h8000; rc = 1'b1; rs = 1'b1; end
      if (rs) begin
        w   = {1'b0, ra} - {1'b0, rb} - 17'(rc);
        eco = ~w[16];
        t   = 32'($signed(ra)) - 32'($signed(rb)) - int'(rc);
      end else begin
        w   = {1'b0, ra} + {1'b0, rb} + 17'(rc);
        eco = w[16];
        t   = 32'($signed(ra)) + 32'($signed(rb)) + int'(rc);
      end
      es  = w[15:0];
      eof = (t > 32767) || (t < -32768);
      a = ra; b = rb; cin = rc; sub = rs; acc_en = 1'b0;
      in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      lat1 = -1; lat4 = -1; lat16 = -1;
      for (int n = 1; n <= 20; n++) begin
        scramble();
        tick();
        if (ov1  && lat1  < 0) lat1  = n;
        if (ov4  && lat4  < 0) lat4  = n;
        if (ov16 && lat16 < 0) lat16 = n;
      end
      n_checks++; if (lat1 !== 16) begin n_fail++; $display("FAIL sweep%0d slice1 latency: got %0d want 16", i, lat1); end
      n_checks++; if (lat4 !== 4) begin n_fail++; $display("FAIL sweep%0d slice4 latency: got %0d want 4", i, lat4); end
      n_checks++; if (lat16 !== 1) begin n_fail++; $display("FAIL sweep%0d slice16 latency: got %0d want 1", i, lat16); end
      n_checks++; if ({s1, co1, of1} !== {es, eco, eof}) begin n_fail++; $display("FAIL sweep%0d slice1 s/cout/ovf: got %h %b %b want %h %b %b", i, s1, co1, of1, es, eco, eof); end
      n_checks++; if ({s4, co4, of4} !== {es, eco, eof}) begin n_fail++; $display("FAIL sweep%0d slice4 s/cout/ovf: got %h %b %b want %h %b %b", i, s4, co4, of4, es, eco, eof); end
      n_checks++; if ({s16, co16, of16} !== {es, eco, eof}) begin n_fail++; $display("FAIL sweep%0d slice16 s/cout/ovf: got %h %b %b want %h %b %b", i, s16, co16, of16, es, eco, eof); end
      pop();
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_accumulate();
    test_back_to_back();
    test_reset_midrun();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
